// File: rtl/pipe_ctrl_v2_if.sv
// Bundle between the pipeline and pipe_ctrl_v2: stall/exception requests in,
// stall vector, flush and redirect PC out.
interface pipe_ctrl_v2_if #(
  parameter int unsigned STAGES        = 7,
  parameter int unsigned NUM_STALL_SRC = 2,
  parameter int unsigned EXC_W         = 2,
  parameter int unsigned ADDR_W        = 32
);
  localparam int unsigned CodeW = (EXC_W > 1) ? $clog2(EXC_W) : 1;

  logic [NUM_STALL_SRC-1:0] stall_req_i;
  logic [EXC_W-1:0]         excepttype_i;
  logic [ADDR_W-1:0]        epc_i;
  logic                     ertn_i;
  logic [STAGES-1:0]        stall;
  logic                     flush;
  logic [ADDR_W-1:0]        new_pc;
  logic [ADDR_W-1:0]        epc_o;
  logic [CodeW-1:0]         exc_code_o;
  logic                     in_exc_o;

  // Pipeline side: raises requests, consumes control.
  modport master (
    output stall_req_i, excepttype_i, epc_i, ertn_i,
    input  stall, flush, new_pc, epc_o, exc_code_o, in_exc_o
  );

  // Controller side.
  modport slave (
    input  stall_req_i, excepttype_i, epc_i, ertn_i,
    output stall, flush, new_pc, epc_o, exc_code_o, in_exc_o
  );
endinterface

// File: rtl/pipe_ctrl_v2.sv
// Pipeline controller: merges stall requesters into a per-stage stall vector,
// takes prioritised exceptions / ertn and drives a multi-cycle flush with redirect PC.
module pipe_ctrl_v2 #(
  parameter int unsigned                    STAGES        = 7,
  parameter int unsigned                    NUM_STALL_SRC = 2,
  parameter logic [4*NUM_STALL_SRC-1:0]     STALL_DEPTH   = 8'h55,
  parameter int unsigned                    EXC_W         = 2,
  parameter int unsigned                    ADDR_W        = 32,
  parameter logic [ADDR_W-1:0]              EXC_BASE      = 32'h0000000c,
  parameter int unsigned                    VECTORED      = 0,
  parameter int unsigned                    VEC_SHIFT     = 2,
  parameter int unsigned                    FLUSH_CYCLES  = 1
) (
  input logic            clk,
  input logic            rst_n,
  pipe_ctrl_v2_if.slave  bus
);
  localparam int unsigned CodeW = (EXC_W > 1) ? $clog2(EXC_W) : 1;

  typedef enum logic {StIdle, StFlush} state_e;

  state_e            r_state, w_state_d;
  logic [3:0]        r_cnt, w_cnt_d;
  logic [STAGES-1:0] r_stall, w_stall_d;
  logic              r_flush, w_flush_d;
  logic [ADDR_W-1:0] r_new_pc, w_new_pc_d;
  logic [ADDR_W-1:0] r_epc, w_epc_d;
  logic [CodeW-1:0]  r_code, w_code_d;
  logic              r_in_exc, w_in_exc_d;

  logic              w_exc_any;
  logic [CodeW-1:0]  w_idx;
  logic [STAGES-1:0] w_stall_mask;
  logic [ADDR_W-1:0] w_entry;
  logic              w_idle_rules;

  // Downward scan so the lowest set bit is the last (winning) assignment.
  always_comb begin
    w_exc_any = |bus.excepttype_i;
    w_idx     = '0;
    for (int i = EXC_W - 1; i >= 0; i--) begin
      if (bus.excepttype_i[i]) w_idx = CodeW'(i);
    end
  end

  always_comb begin
    w_stall_mask = '0;
    for (int j = 0; j < NUM_STALL_SRC; j++) begin
      if (bus.stall_req_i[j]) begin
        for (int s = 0; s < STAGES; s++) begin
          if (s < int'(STALL_DEPTH[4*j +: 4])) w_stall_mask[s] = 1'b1;
        end
      end
    end
  end

  assign w_entry = (VECTORED != 0) ? EXC_BASE + (ADDR_W'(w_idx) << VEC_SHIFT) : EXC_BASE;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_stall_d    = r_stall;
    w_flush_d    = r_flush;
    w_new_pc_d   = r_new_pc;
    w_epc_d      = r_epc;
    w_code_d     = r_code;
    w_in_exc_d   = r_in_exc;
    w_idle_rules = 1'b0;

    unique case (r_state)
      StIdle: w_idle_rules = 1'b1;
      StFlush: begin
        // Exit edge evaluates requests like IDLE; earlier flush cycles ignore them.
        if (r_cnt == 4'd0) begin
          w_state_d    = StIdle;
          w_idle_rules = 1'b1;
        end else begin
          w_cnt_d   = r_cnt - 4'd1;
          w_stall_d = '0;
          w_flush_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_idle_rules) begin
      if (w_exc_any) begin
        w_flush_d  = 1'b1;
        w_stall_d  = '0;
        w_new_pc_d = w_entry;
        w_epc_d    = bus.epc_i;
        w_code_d   = w_idx;
        w_in_exc_d = 1'b1;
        w_cnt_d    = 4'(FLUSH_CYCLES - 1);
        w_state_d  = (FLUSH_CYCLES > 1) ? StFlush : StIdle;
      end else if (bus.ertn_i) begin
        w_flush_d  = 1'b1;
        w_stall_d  = '0;
        w_new_pc_d = r_epc;
        w_in_exc_d = 1'b0;
        w_cnt_d    = 4'(FLUSH_CYCLES - 1);
        w_state_d  = (FLUSH_CYCLES > 1) ? StFlush : StIdle;
      end else begin
        w_stall_d  = w_stall_mask;
        w_flush_d  = 1'b0;
        w_new_pc_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_stall  <= '0;
      r_flush  <= 1'b0;
      r_new_pc <= '0;
      r_epc    <= '0;
      r_code   <= '0;
      r_in_exc <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_stall  <= w_stall_d;
      r_flush  <= w_flush_d;
      r_new_pc <= w_new_pc_d;
      r_epc    <= w_epc_d;
      r_code   <= w_code_d;
      r_in_exc <= w_in_exc_d;
    end
  end

  assign bus.stall      = r_stall;
  assign bus.flush      = r_flush;
  assign bus.new_pc     = r_new_pc;
  assign bus.epc_o      = r_epc;
  assign bus.exc_code_o = r_code;
  assign bus.in_exc_o   = r_in_exc;

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Bench for pipe_ctrl_v2: two configurations driven in lockstep, checked against a
// cycle-level behavioural model plus directed constant expectations.
module tb_pipe_ctrl_v2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req;
  logic [1:0]  exc;
  logic [31:0] epc;
  logic        ertn;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl_v2_if bus_a ();
  pipe_ctrl_v2_if bus_b ();

  assign bus_a.stall_req_i  = req;
  assign bus_a.excepttype_i = exc;
  assign bus_a.epc_i        = epc;
  assign bus_a.ertn_i       = ertn;
  assign bus_b.stall_req_i  = req;
  assign bus_b.excepttype_i = exc;
  assign bus_b.epc_i        = epc;
  assign bus_b.ertn_i       = ertn;

  pipe_ctrl_v2 u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  pipe_ctrl_v2 #(
    .STALL_DEPTH  (8'h25),
    .VECTORED     (1),
    .FLUSH_CYCLES (3)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    int          left;   // flush cycles still to run after the current one
    logic [6:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] epc;
    int          code;
    logic        in_exc;
  } mdl_t;

  mdl_t mdl_a, mdl_b;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.left = 0; m.stall = '0; m.flush = 1'b0; m.new_pc = '0;
    m.epc = '0; m.code = 0; m.in_exc = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, logic [7:0] depth, bit vect, int fc,
                                    logic [1:0] r, logic [1:0] x, logic [31:0] pc, logic rt);
    mdl_t n = s;
    int   idx;
    int   mask;
    if (s.left > 0) begin
      n.left = s.left - 1;
      return n;
    end
    if (x != 0) begin
      idx = x[0] ? 0 : 1;
      n.flush = 1'b1; n.stall = '0;
      n.new_pc = vect ? 32'h0000000c + 32'(idx * 4) : 32'h0000000c;
      n.epc = pc; n.code = idx; n.in_exc = 1'b1; n.left = fc - 1;
    end else if (rt) begin
      n.flush = 1'b1; n.stall = '0; n.new_pc = s.epc; n.in_exc = 1'b0; n.left = fc - 1;
    end else begin
      mask = 0;
      for (int j = 0; j < 2; j++) begin
        if (r[j]) mask = mask | ((1 << int'(depth[4*j +: 4])) - 1);
      end
      n.stall = 7'(mask); n.flush = 1'b0; n.new_pc = '0;
    end
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_dut(input string p, input mdl_t m, input logic [6:0] st, input logic fl,
                         input logic [31:0] npc, input logic [31:0] ep, input logic cd,
                         input logic ie);
    check_eq({p, "_stall"}, 64'(st), 64'(m.stall));
    check_eq({p, "_flush"}, 64'(fl), 64'(m.flush));
    check_eq({p, "_new_pc"}, 64'(npc), 64'(m.new_pc));
    check_eq({p, "_epc"}, 64'(ep), 64'(m.epc));
    check_eq({p, "_code"}, 64'(cd), 64'(m.code));
    check_eq({p, "_in_exc"}, 64'(ie), 64'(m.in_exc));
    check_eq({p, "_flush_vs_stall"}, 64'(fl && (st != 0)), 64'd0);
    check_eq({p, "_pc_idle_zero"}, 64'(!fl && (npc != 0)), 64'd0);
  endtask

  task automatic cmp_all();
    cmp_dut("a", mdl_a, bus_a.stall, bus_a.flush, bus_a.new_pc, bus_a.epc_o,
            bus_a.exc_code_o, bus_a.in_exc_o);
    cmp_dut("b", mdl_b, bus_b.stall, bus_b.flush, bus_b.new_pc, bus_b.epc_o,
            bus_b.exc_code_o, bus_b.in_exc_o);
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_a = mdl_step(mdl_a, 8'h55, 1'b0, 1, req, exc, epc, ertn);
    mdl_b = mdl_step(mdl_b, 8'h25, 1'b1, 3, req, exc, epc, ertn);
    #1;
    cmp_all();
  endtask

  task automatic idle_inputs();
    req = '0; exc = '0; epc = '0; ertn = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    idle_inputs();
    mdl_a = mdl_reset();
    mdl_b = mdl_reset();
    #2;
    cmp_all();
    #10 rst_n = 1'b1;
    idle_cycles(2);

    // Stall merging
    req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("dir_a_stall_01", 64'(bus_a.stall), 64'h1f);
      check_eq("dir_b_stall_01", 64'(bus_b.stall), 64'h1f);
    end
    req = 2'b11; tick();
    check_eq("dir_b_stall_11", 64'(bus_b.stall), 64'h1f);
    req = 2'b10; tick();
    check_eq("dir_b_stall_10", 64'(bus_b.stall), 64'h03);
    check_eq("dir_a_stall_10", 64'(bus_a.stall), 64'h1f);
    idle_inputs(); tick();
    check_eq("dir_a_stall_off", 64'(bus_a.stall), 64'h0);

    // Exception beats stall requests
    exc = 2'b11; epc = 32'h1c000040; req = 2'b11; tick();
    check_eq("dir_a_exc_flush", 64'(bus_a.flush), 64'h1);
    check_eq("dir_a_exc_stall", 64'(bus_a.stall), 64'h0);
    check_eq("dir_a_exc_pc", 64'(bus_a.new_pc), 64'h0000000c);
    check_eq("dir_a_exc_epc", 64'(bus_a.epc_o), 64'h1c000040);
    check_eq("dir_a_exc_code", 64'(bus_a.exc_code_o), 64'h0);
    check_eq("dir_a_exc_inexc", 64'(bus_a.in_exc_o), 64'h1);
    idle_cycles(4);

    // Exception return
    ertn = 1'b1; tick();
    check_eq("dir_a_ertn_pc", 64'(bus_a.new_pc), 64'h1c000040);
    check_eq("dir_a_ertn_inexc", 64'(bus_a.in_exc_o), 64'h0);
    check_eq("dir_b_ertn_flush", 64'(bus_b.flush), 64'h1);
    idle_cycles(4);

    // Vectored entry
    exc = 2'b10; epc = 32'h1c000080; tick();
    check_eq("dir_b_vec_pc", 64'(bus_b.new_pc), 64'h00000010);
    check_eq("dir_b_vec_code", 64'(bus_b.exc_code_o), 64'h1);
    check_eq("dir_a_fixed_pc", 64'(bus_a.new_pc), 64'h0000000c);
    idle_cycles(4);

    // Exception wins over ertn
    exc = 2'b01; ertn = 1'b1; epc = 32'h1c000100; tick();
    check_eq("dir_a_exc_ertn_pc", 64'(bus_a.new_pc), 64'h0000000c);
    check_eq("dir_a_exc_ertn_inexc", 64'(bus_a.in_exc_o), 64'h1);
    idle_cycles(4);

    // Multi-cycle flush ignores traffic before its exit edge
    exc = 2'b01; epc = 32'h1c000200; tick();
    check_eq("dir_b_fl1", 64'(bus_b.flush), 64'h1);
    exc = 2'b10; epc = 32'h1c000300; req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("dir_b_fl_hold", 64'(bus_b.flush), 64'h1);
      check_eq("dir_b_fl_pc", 64'(bus_b.new_pc), 64'h0000000c);
      check_eq("dir_b_fl_stall", 64'(bus_b.stall), 64'h0);
      check_eq("dir_b_fl_epc", 64'(bus_b.epc_o), 64'h1c000200);
    end
    idle_inputs(); tick();
    check_eq("dir_b_fl_end", 64'(bus_b.flush), 64'h0);
    check_eq("dir_b_fl_end_pc", 64'(bus_b.new_pc), 64'h0);
    idle_cycles(2);

    // Asynchronous reset in the middle of a flush
    exc = 2'b01; epc = 32'h1c000400; tick();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    mdl_a = mdl_reset();
    mdl_b = mdl_reset();
    cmp_all();
    check_eq("dir_b_rst_flush", 64'(bus_b.flush), 64'h0);
    #2 rst_n = 1'b1;
    idle_cycles(3);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      req  = 2'($urandom);
      exc  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ertn = ($urandom_range(0, 9) == 0);
      epc  = $urandom;
      tick();
    end
    idle_cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
